hazard_unit: RTL and testbench

//  Hazard detection and forwarding control for the 5-stage pipeline. Produces the stall/flush

---
 rtl/hazard_unit_if.sv | 52 +++++
 rtl/hazard_unit.sv | 126 ++++++++++++
 tb/tb_hazard_unit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline control path and hazard_unit.
//   master : pipeline side. It drives the ID/EX/MEM/WB status and samples the requests.
//   slave  : hazard_unit. It samples the status and drives stall, flush, fwd_a/b and md_busy/md_abort.
interface hazard_unit_if #(
  parameter int unsigned REG_W = 5
);
  // ID stage
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_is_md;
  // EX stage
  logic             ex_valid;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic             ex_md_start;
  logic             ex_mispredict;
  // MEM / WB writeback info
  logic             mem_valid;
  logic             mem_reg_write;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid;
  logic             wb_reg_write;
  logic [REG_W-1:0] wb_rd;
  logic             mem_exception;
  // Requests back to the pipeline
  logic [4:0]       stall;
  logic [4:0]       flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             md_busy;
  logic             md_abort;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_md,
    output ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_md_start, ex_mispredict,
    output mem_valid, mem_reg_write, mem_rd, wb_valid, wb_reg_write, wb_rd, mem_exception,
    input  stall, flush, fwd_a, fwd_b, md_busy, md_abort
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_md,
    input  ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_md_start, ex_mispredict,
    input  mem_valid, mem_reg_write, mem_rd, wb_valid, wb_reg_write, wb_rd, mem_exception,
    output stall, flush, fwd_a, fwd_b, md_busy, md_abort
  );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// It raises a stall or flush request, with at most one bit set in each vector.
// It selects the EX operand forwarding sources.
// It tracks the occupancy of the multi-cycle mult/div unit.
// Stage bit order in stall/flush: [4]=IF [3]=ID [2]=EX [1]=MEM [0]=WB.
// Ports:
//   clk - clock
//   rst - asynchronous reset, active-low
//   bus - hazard_unit_if.slave
//         stall, flush, fwd_a, fwd_b and md_abort are combinational.
//         md_busy is a decode of the registered mult/div state.
module hazard_unit #(
  parameter int unsigned MD_LAT = 8,
  parameter int unsigned REG_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  hazard_unit_if.slave  bus
);

  localparam int unsigned CNT_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

  localparam logic [4:0] REQ_NONE = 5'b00000;
  localparam logic [4:0] REQ_ID   = 5'b01000;
  localparam logic [4:0] REQ_MEM  = 5'b00010;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic hz_load_use;
  logic hz_md_wait;
  logic mem_fwd_ok;
  logic wb_fwd_ok;

  // State register: mult/div state and remaining-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state logic. An exception in MEM kills the mult/div that is in flight.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (bus.ex_valid && bus.ex_md_start && !bus.mem_exception) begin
          state_d  = MD_BUSY;
          md_cnt_d = CNT_W'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (bus.mem_exception) begin
          state_d  = MD_IDLE;
          md_cnt_d = '0;
        end else if (md_cnt_q == '0) begin
          state_d  = MD_IDLE;
        end else begin
          md_cnt_d = md_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = MD_IDLE;
        md_cnt_d = '0;
      end
    endcase
  end

  // Output logic: hazard priority, forwarding selects, mult/div status.
  always_comb begin
    bus.stall    = REQ_NONE;
    bus.flush    = REQ_NONE;
    bus.fwd_a    = FWD_RF;
    bus.fwd_b    = FWD_RF;
    bus.md_busy  = (state_q == MD_BUSY);
    bus.md_abort = (state_q == MD_BUSY) && bus.mem_exception;

    // A load result is not available in time for an ID consumer. Register 0 is exempt.
    hz_load_use = bus.id_valid && bus.ex_valid && bus.ex_mem_read && bus.ex_reg_write &&
                  (bus.ex_rd != '0) &&
                  ((bus.id_use_rs && (bus.id_rs == bus.ex_rd)) ||
                   (bus.id_use_rt && (bus.id_rt == bus.ex_rd)));
    // A HI/LO user waits while the unit is busy, or while a mult/div is issuing this cycle.
    hz_md_wait  = bus.id_valid && bus.id_is_md &&
                  ((state_q == MD_BUSY) || (bus.ex_valid && bus.ex_md_start));

    if (bus.mem_exception) begin
      bus.flush = REQ_MEM;
    end else if (bus.ex_mispredict) begin
      bus.flush = REQ_ID;
    end else if (hz_load_use || hz_md_wait) begin
      bus.stall = REQ_ID;
    end

    // The younger result (MEM) wins over WB.
    mem_fwd_ok = bus.mem_valid && bus.mem_reg_write && (bus.mem_rd != '0);
    wb_fwd_ok  = bus.wb_valid && bus.wb_reg_write && (bus.wb_rd != '0);

    if (mem_fwd_ok && (bus.mem_rd == bus.ex_rs)) begin
      bus.fwd_a = FWD_MEM;
    end else if (wb_fwd_ok && (bus.wb_rd == bus.ex_rs)) begin
      bus.fwd_a = FWD_WB;
    end

    if (mem_fwd_ok && (bus.mem_rd == bus.ex_rt)) begin
      bus.fwd_b = FWD_MEM;
    end else if (wb_fwd_ok && (bus.wb_rd == bus.ex_rt)) begin
      bus.fwd_b = FWD_WB;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit.
// It runs directed pipeline scenarios, then randomized traffic.
// All checks compare against a cycle-count reference model of the mult/div unit.
module tb_hazard_unit;

  localparam int unsigned MD_LAT = 8;
  localparam int unsigned REG_W  = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_unit_if #(.REG_W(REG_W)) bus ();

  hazard_unit #(.MD_LAT(MD_LAT), .REG_W(REG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors  = 0;
  int checks  = 0;
  int md_left = 0;   // reference: busy cycles still owed by the mult/div unit

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [REG_W-1:0] src);
    if (bus.mem_valid && bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == src) return 2'b01;
    if (bus.wb_valid && bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic check_model();
    bit         busy, load_use, md_wait;
    logic [4:0] e_stall, e_flush;
    busy     = (md_left > 0);
    load_use = bus.id_valid && bus.ex_valid && bus.ex_mem_read && bus.ex_reg_write &&
               bus.ex_rd != 0 &&
               ((bus.id_use_rs && bus.id_rs == bus.ex_rd) || (bus.id_use_rt && bus.id_rt == bus.ex_rd));
    md_wait  = bus.id_valid && bus.id_is_md && (busy || (bus.ex_valid && bus.ex_md_start));
    e_stall  = 5'b0;
    e_flush  = 5'b0;
    if (bus.mem_exception)      e_flush = 5'b00010;
    else if (bus.ex_mispredict) e_flush = 5'b01000;
    else if (load_use || md_wait) e_stall = 5'b01000;
    check_eq("stall",    32'(bus.stall),    32'(e_stall));
    check_eq("flush",    32'(bus.flush),    32'(e_flush));
    check_eq("fwd_a",    32'(bus.fwd_a),    32'(ref_fwd(bus.ex_rs)));
    check_eq("fwd_b",    32'(bus.fwd_b),    32'(ref_fwd(bus.ex_rt)));
    check_eq("md_busy",  32'(bus.md_busy),  32'(busy));
    check_eq("md_abort", 32'(bus.md_abort), 32'(busy && bus.mem_exception));
  endtask

  // Entered just after a negedge with inputs applied. It checks, then clocks the model,
  // then returns at the next negedge.
  task automatic step();
    #1 check_model();
    @(posedge clk);
    if (bus.mem_exception)                     md_left = 0;
    else if (md_left > 0)                      md_left--;
    else if (bus.ex_valid && bus.ex_md_start)  md_left = MD_LAT;
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_use_rs = 0; bus.id_use_rt = 0;
    bus.id_is_md = 0;
    bus.ex_valid = 0; bus.ex_rs = '0; bus.ex_rt = '0; bus.ex_rd = '0; bus.ex_reg_write = 0;
    bus.ex_mem_read = 0; bus.ex_md_start = 0; bus.ex_mispredict = 0;
    bus.mem_valid = 0; bus.mem_reg_write = 0; bus.mem_rd = '0;
    bus.wb_valid = 0; bus.wb_reg_write = 0; bus.wb_rd = '0; bus.mem_exception = 0;
  endtask

  task automatic set_load(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] src);
    bus.ex_valid = 1; bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd = rd;
    bus.id_valid = 1; bus.id_use_rs = 1; bus.id_rs = src;
  endtask

  initial begin
    int n_stall, n_busy;
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    #1 check_eq("rst_md_busy", 32'(bus.md_busy), 32'd0);
    check_eq("rst_stall", 32'(bus.stall), 32'd0);
    check_eq("rst_flush", 32'(bus.flush), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Load-use on $5, then a bubble in EX.
    set_load(5'd5, 5'd5);
    #1 check_eq("lu_stall", 32'(bus.stall), 32'h08);
    check_eq("lu_flush", 32'(bus.flush), 32'h00);
    step();
    bus.ex_valid = 0;
    #1 check_eq("lu_bubble", 32'(bus.stall), 32'h00);
    step();

    // A load into $0 never causes a hazard.
    clear_inputs();
    set_load(5'd0, 5'd0);
    #1 check_eq("lu_r0", 32'(bus.stall), 32'h00);
    step();

    // mult in EX, mflo in ID: 9 stall cycles, 8 busy cycles.
    clear_inputs();
    bus.ex_valid = 1; bus.ex_md_start = 1; bus.id_valid = 1; bus.id_is_md = 1;
    n_stall = 0; n_busy = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (bus.stall == 5'b01000) n_stall++;
      if (bus.md_busy) n_busy++;
      step();
      bus.ex_valid = 0; bus.ex_md_start = 0;
    end
    check_eq("md_stall_cycles", 32'(n_stall), 32'd9);
    check_eq("md_busy_cycles",  32'(n_busy),  32'd8);

    // A mispredict wins over a concurrent load-use.
    clear_inputs();
    set_load(5'd9, 5'd9);
    bus.ex_mispredict = 1;
    #1 check_eq("mp_flush", 32'(bus.flush), 32'h08);
    check_eq("mp_stall", 32'(bus.stall), 32'h00);
    step();

    // Exception while md_cnt == 3 aborts the mult/div.
    clear_inputs();
    bus.ex_valid = 1; bus.ex_md_start = 1;
    step();
    clear_inputs();
    repeat (4) step();
    bus.mem_exception = 1;
    #1 check_eq("ex_flush", 32'(bus.flush), 32'h02);
    check_eq("ex_abort", 32'(bus.md_abort), 32'd1);
    step();
    bus.mem_exception = 0;
    #1 check_eq("ex_busy_after", 32'(bus.md_busy), 32'd0);
    step();

    // Forwarding: MEM beats WB, then WB alone.
    clear_inputs();
    bus.ex_rs = 5'd7; bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_rd = 5'd7;
    bus.wb_valid = 1; bus.wb_reg_write = 1; bus.wb_rd = 5'd7;
    #1 check_eq("fwd_mem", 32'(bus.fwd_a), 32'd1);
    step();
    bus.mem_reg_write = 0;
    #1 check_eq("fwd_wb", 32'(bus.fwd_a), 32'd2);
    step();

    // Reset in the middle of a busy period: idle immediately, with no abort pulse.
    clear_inputs();
    bus.ex_valid = 1; bus.ex_md_start = 1;
    step();
    clear_inputs();
    repeat (3) step();
    #2 rst = 1'b0;
    #1 check_eq("rst_mid_busy",  32'(bus.md_busy),  32'd0);
    check_eq("rst_mid_abort", 32'(bus.md_abort), 32'd0);
    md_left = 0;
    @(negedge clk);
    rst = 1'b1;
    step();

    // Randomized traffic. Register indices are kept small so that matches are frequent.
    // A mult/div is never issued while the unit is busy.
    for (int i = 0; i < 600; i++) begin
      bus.id_valid      = ($urandom_range(0, 3) != 0);
      bus.id_rs         = REG_W'($urandom_range(0, 3));
      bus.id_rt         = REG_W'($urandom_range(0, 3));
      bus.id_use_rs     = 1'($urandom);
      bus.id_use_rt     = 1'($urandom);
      bus.id_is_md      = ($urandom_range(0, 3) == 0);
      bus.ex_valid      = ($urandom_range(0, 3) != 0);
      bus.ex_rs         = REG_W'($urandom_range(0, 3));
      bus.ex_rt         = REG_W'($urandom_range(0, 3));
      bus.ex_rd         = REG_W'($urandom_range(0, 3));
      bus.ex_reg_write  = 1'($urandom);
      bus.ex_mem_read   = 1'($urandom);
      bus.ex_md_start   = (md_left == 0) && ($urandom_range(0, 7) == 0);
      bus.ex_mispredict = ($urandom_range(0, 9) == 0);
      bus.mem_valid     = 1'($urandom);
      bus.mem_reg_write = 1'($urandom);
      bus.mem_rd        = REG_W'($urandom_range(0, 3));
      bus.wb_valid      = 1'($urandom);
      bus.wb_reg_write  = 1'($urandom);
      bus.wb_rd         = REG_W'($urandom_range(0, 3));
      bus.mem_exception = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
